// File: rtl/quad_encoder_tx_pkg.sv
// quad_pkg: shared types and helpers for the quadrature encoder transmitter.
//   state_e     : transmitter states (IDLE, RUN)
//   FWD / REV   : command direction encoding
//   phase_to_ab : maps the 2-bit phase counter onto the Gray-coded {a,b} pair
package quad_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;

    // Counting the phase up walks {a,b} through 00 -> 01 -> 11 -> 10, so a
    // plain binary increment/decrement of the phase yields a Gray sequence.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
        return {ph[1], ph[1] ^ ph[0]};
    endfunction

endpackage

// File: rtl/quad_rate_div.sv
// quad_rate_div: free-running tick divider for quadrature step timing.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : hold the count at zero (no tick while asserted)
//   tick       : one-cycle strobe every DIV clocks while clr is low
module quad_rate_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = !clr && (cnt_q == TERMINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/quad_encoder_tx.sv
// quad_encoder_tx: quadrature encoder transmitter.
// Accepts step commands over valid/ready and emits one Gray-coded edge on
// quad_a/quad_b every STEP_DIV clocks, tracking the emitted position.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only while IDLE)
//   cmd_dir, cmd_steps    : direction (FWD/REV) and edge count of a command
//   abort                 : terminate the running command, no further edges
//   quad_a, quad_b        : registered encoder channels
//   quad_i                : registered index pulse (constant 0 unless enabled)
//   busy, done            : RUN indicator, completion/abort pulse
//   pos                   : emitted edge count, modulo 2^POS_W
// Build option: define QUAD_INDEX_EN to generate the index pulse on quad_i.
module quad_encoder_tx
    import quad_pkg::*;
#(
    parameter int unsigned STEP_DIV     = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned POS_W        = 9,
    parameter int unsigned IDX_PERIOD_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             abort,
    output logic             quad_a,
    output logic             quad_b,
    output logic             quad_i,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);

    state_e             state_q;
    logic               dir_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [1:0]         ph_q;
    logic [1:0]         ab_q;
    logic [POS_W-1:0]   pos_q;
    logic               done_q;
    logic               tick;

    logic [1:0]         ph_d;
    logic [POS_W-1:0]   pos_d;
    logic               step_fire;

    // Divider is held cleared outside RUN, so a freshly accepted command
    // always sees its first terminal count STEP_DIV clocks after acceptance.
    quad_rate_div #(
        .DIV (STEP_DIV)
    ) u_rate_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != RUN),
        .tick  (tick)
    );

    always_comb begin
        if (dir_q == REV) begin
            ph_d  = ph_q - 2'd1;
            pos_d = pos_q - 1'b1;
        end else begin
            ph_d  = ph_q + 2'd1;
            pos_d = pos_q + 1'b1;
        end
    end

    // Abort takes priority over a coincident terminal count.
    assign step_fire = (state_q == RUN) && !abort && tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dir_q       <= FWD;
            remaining_q <= '0;
            ph_q        <= 2'd0;
            ab_q        <= 2'b00;
            pos_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_q       <= cmd_dir;
                        remaining_q <= cmd_steps;
                        if (cmd_steps == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (step_fire) begin
                        ph_q        <= ph_d;
                        ab_q        <= phase_to_ab(ph_d);
                        pos_q       <= pos_d;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef QUAD_INDEX_EN
    logic idx_q;

    // Registered together with the step, so the pulse occupies the cycle
    // right after the edge that lands on an index position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 1'b0;
        end else begin
            idx_q <= step_fire && (pos_d[IDX_PERIOD_W-1:0] == '0);
        end
    end

    assign quad_i = idx_q;
`else
    // Index disabled: the port is kept and driven low; the period parameter
    // only folds into this constant.
    localparam logic IDX_OFF = (IDX_PERIOD_W == 0) ? 1'b0 : 1'b0;

    assign quad_i = IDX_OFF;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign quad_a    = ab_q[1];
    assign quad_b    = ab_q[0];
    assign pos       = pos_q;

endmodule
